keypad_entry: RTL and testbench

KEYPAD_ENTRY -- requirements
Module: keypad_entry

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/clk_div_1hz.sv | 46 ++++
 rtl/keypad_entry.sv | 177 +++++++++++++++++
 tb/tb_keypad_entry.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared defaults, debounce FSM state type and key-decode helpers
//             for the keypad entry block.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

    localparam int N_KEYS_DEF       = 10;
    localparam int DEBOUNCE_CYC_DEF = 4;
    localparam int DIV_DEF          = 100;
    localparam int DIGITS_DEF       = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } kp_state_e;

    // True when exactly one key line is active
    function automatic logic key_onehot(input logic [9:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

    // Index of the highest active line; only meaningful when key_onehot is true
    function automatic logic [3:0] key_encode(input logic [9:0] v);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) code = 4'(i);
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_1hz.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_1hz
//  Purpose  : Free-running divide-by-DIV counter producing a 50% duty divided
//             clock and a one-cycle tick on the last count.
//  Revision : 1.0  initial release
// ============================================================================
module clk_div_1hz #(
    parameter int DIV = keypad_pkg::DIV_DEF
) (
    input  logic clock,
    input  logic reset,
    output logic pgt_1Hz,
    output logic tick
);

    localparam int              CW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]   HALF = CW'(DIV / 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pgt_q;

    // Next count, wrapping after DIV-1
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    // Counter and divided clock; the output flop looks at the next count so it
    // stays aligned with the counter value it describes
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            pgt_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pgt_q <= (cnt_d < HALF);
        end
    end

    assign pgt_1Hz = pgt_q;
    assign tick    = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_entry
//  Purpose  : Synchronizes and debounces a one-hot keypad, shifts accepted
//             key codes into a BCD entry buffer and provides a 1 Hz divider.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int N_KEYS       = N_KEYS_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int DIV          = DIV_DEF,
    parameter int DIGITS       = DIGITS_DEF
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         en,
    input  logic [N_KEYS-1:0]            keypad,
    input  logic                         clear_entry,
    output logic [3:0]                   BCD,
    output logic [4*DIGITS-1:0]          digits,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic                         full,
    output logic                         loadn,
    output logic                         pgt_1Hz,
    output logic                         tick
);

    localparam int                CNT_W    = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DIGITS);
    localparam logic [7:0]        DEB      = 8'(DEBOUNCE_CYC);

    logic [N_KEYS-1:0]   sync1_q;
    logic [N_KEYS-1:0]   sync2_q;
    logic [9:0]          keys_ext;
    logic                key_valid;
    logic [3:0]          key_code;

    kp_state_e           state_q, state_d;
    logic [7:0]          stab_q, stab_d, stab_inc;
    logic [3:0]          code_q, code_d;
    logic                accept;

    logic [3:0]          bcd_q;
    logic [4*DIGITS-1:0] digits_q;
    logic [CNT_W-1:0]    count_q;
    logic                loadn_q;

    // Two-flop synchronizer on the raw key lines
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= keypad;
            sync2_q <= sync1_q;
        end
    end

    // Decode the synchronized lines; zero or multiple lines mean "no key"
    always_comb begin
        keys_ext                = '0;
        keys_ext[N_KEYS-1:0]    = sync2_q;
        key_valid               = key_onehot(keys_ext);
        key_code                = key_encode(keys_ext);
    end

    // Debounce FSM next-state: stable press accepted once, stable release re-arms
    always_comb begin
        state_d  = state_q;
        stab_d   = stab_q;
        code_d   = code_q;
        accept   = 1'b0;
        stab_inc = stab_q + 8'd1;
        if (!en) begin
            state_d = ST_IDLE;
            stab_d  = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_valid) begin
                        code_d  = key_code;
                        stab_d  = 8'd1;
                        state_d = ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (key_valid && (key_code == code_q)) begin
                        stab_d = stab_inc;
                        if (stab_inc >= DEB) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end
                    end else begin
                        stab_d  = 8'd0;
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (!key_valid) begin
                        stab_d  = 8'd1;
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (key_valid) begin
                        state_d = ST_HELD;
                    end else begin
                        stab_d = stab_inc;
                        if (stab_inc >= DEB) begin
                            stab_d  = 8'd0;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    stab_d  = 8'd0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Debounce FSM state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            stab_q  <= 8'd0;
            code_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            code_q  <= code_d;
        end
    end

    // Entry buffer: clear beats a simultaneous acceptance, which is then dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            bcd_q    <= 4'd0;
            digits_q <= '0;
            count_q  <= '0;
            loadn_q  <= 1'b1;
        end else begin
            loadn_q <= 1'b1;
            if (clear_entry) begin
                digits_q <= '0;
                count_q  <= '0;
            end else if (accept) begin
                loadn_q  <= 1'b0;
                bcd_q    <= code_q;
                digits_q <= (digits_q << 4) | (4*DIGITS)'(code_q);
                if (count_q != FULL_CNT) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
        end
    end

    assign BCD    = bcd_q;
    assign digits = digits_q;
    assign count  = count_q;
    assign full   = (count_q == FULL_CNT);
    assign loadn  = loadn_q;

    clk_div_1hz #(
        .DIV     (DIV)
    ) u_clk_div (
        .clock   (clock),
        .reset   (reset),
        .pgt_1Hz (pgt_1Hz),
        .tick    (tick)
    );

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_entry
//  Purpose  : Directed self-checking bench for keypad_entry (default params).
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_entry;

    logic        clock;
    logic        reset;
    logic        en;
    logic [9:0]  keypad;
    logic        clear_entry;
    logic [3:0]  BCD;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        full;
    logic        loadn;
    logic        pgt_1Hz;
    logic        tick;

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;
    int p0;

    keypad_entry dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .keypad      (keypad),
        .clear_entry (clear_entry),
        .BCD         (BCD),
        .digits      (digits),
        .count       (count),
        .full        (full),
        .loadn       (loadn),
        .pgt_1Hz     (pgt_1Hz),
        .tick        (tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count loadn pulses, sampled mid-cycle
    always @(negedge clock) begin
        if (loadn === 1'b0) pulses++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; keypad = '0; clear_entry = 1'b0;
        cyc(3);
        chk("rst_bcd",    32'(BCD),     32'h0);
        chk("rst_digits", 32'(digits),  32'h0);
        chk("rst_count",  32'(count),   32'h0);
        chk("rst_full",   32'(full),    32'h0);
        chk("rst_loadn",  32'(loadn),   32'h1);
        chk("rst_pgt",    32'(pgt_1Hz), 32'h0);
        chk("rst_tick",   32'(tick),    32'h0);

        // Divider: cycle i means divider count i after reset release
        reset = 1'b0;
        for (int i = 0; i < 120; i++) begin
            chk($sformatf("div_tick@%0d", i), 32'(tick),    32'((i % 100) == 99));
            chk($sformatf("div_pgt@%0d", i),  32'(pgt_1Hz), 32'((i != 0) && ((i % 100) < 50)));
            cyc(1);
        end
        reset = 1'b1;
        cyc(1);
        chk("div_rst_pgt",  32'(pgt_1Hz), 32'h0);
        chk("div_rst_tick", 32'(tick),    32'h0);
        reset = 1'b0;
        for (int j = 0; j < 130; j++) begin
            chk($sformatf("div2_tick@%0d", j), 32'(tick),    32'((j % 100) == 99));
            chk($sformatf("div2_pgt@%0d", j),  32'(pgt_1Hz), 32'((j != 0) && ((j % 100) < 50)));
            cyc(1);
        end

        // Fresh reset for the keypad path
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        en = 1'b1;

        // Key 0: accepted 2 sync + 4 debounce edges after the press
        p0 = pulses;
        keypad = 10'b0000000001;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            chk($sformatf("k0_loadn@%0d", k), 32'(loadn), (k == 6) ? 32'h0 : 32'h1);
        end
        keypad = '0;
        cyc(8);
        chk("k0_pulses", 32'(pulses - p0), 32'd1);
        chk("k0_bcd",    32'(BCD),         32'h0);
        chk("k0_count",  32'(count),       32'd1);

        // Glitch shorter than the debounce window
        p0 = pulses;
        keypad = 10'b0000010000;
        cyc(3);
        keypad = '0;
        cyc(10);
        chk("glitch_pulses", 32'(pulses - p0), 32'd0);
        chk("glitch_digits", 32'(digits),      32'h0);
        chk("glitch_count",  32'(count),       32'd1);

        // Keys 1..5 fill and overflow the 4-digit buffer
        p0 = pulses;
        for (int key = 1; key <= 5; key++) begin
            keypad = 10'b1 << key;
            cyc(8);
            keypad = '0;
            cyc(8);
        end
        chk("seq_digits", 32'(digits),      32'h2345);
        chk("seq_count",  32'(count),       32'd4);
        chk("seq_full",   32'(full),        32'd1);
        chk("seq_pulses", 32'(pulses - p0), 32'd5);
        chk("seq_bcd",    32'(BCD),         32'h5);

        // Key 9 held while disabled, then enabled
        en = 1'b0;
        keypad = 10'b1000000000;
        p0 = pulses;
        cyc(20);
        chk("dis_pulses", 32'(pulses - p0), 32'd0);
        chk("dis_digits", 32'(digits),      32'h2345);
        en = 1'b1;
        cyc(10);
        chk("en_pulses", 32'(pulses - p0), 32'd1);
        chk("en_bcd",    32'(BCD),         32'h9);
        chk("en_digits", 32'(digits),      32'h3459);
        chk("en_count",  32'(count),       32'd4);
        keypad = '0;
        cyc(10);

        // Standalone clear keeps BCD
        clear_entry = 1'b1;
        cyc(1);
        clear_entry = 1'b0;
        chk("clr_count",  32'(count),  32'd0);
        chk("clr_digits", 32'(digits), 32'h0);
        chk("clr_full",   32'(full),   32'd0);
        chk("clr_bcd",    32'(BCD),    32'h9);

        keypad = 10'b1 << 6;
        cyc(8);
        keypad = '0;
        cyc(8);
        chk("k6_digits", 32'(digits), 32'h0006);
        chk("k6_count",  32'(count),  32'd1);

        // Two keys at once is "no key"
        p0 = pulses;
        keypad = 10'b0000000011;
        cyc(20);
        keypad = '0;
        cyc(5);
        chk("multi_pulses", 32'(pulses - p0), 32'd0);
        chk("multi_count",  32'(count),       32'd1);

        // Clear coincident with the accept edge of key 7 wins
        keypad = 10'b1 << 7;
        cyc(5);
        clear_entry = 1'b1;
        cyc(1);
        clear_entry = 1'b0;
        chk("clracc_count",  32'(count),  32'd0);
        chk("clracc_digits", 32'(digits), 32'h0);
        p0 = pulses;
        cyc(10);
        chk("held_pulses", 32'(pulses - p0), 32'd0);
        chk("held_count",  32'(count),       32'd0);
        keypad = '0;
        cyc(8);
        keypad = 10'b1 << 3;
        cyc(8);
        keypad = '0;
        cyc(8);
        chk("k3_digits", 32'(digits), 32'h0003);
        chk("k3_count",  32'(count),  32'd1);
        chk("k3_bcd",    32'(BCD),    32'h3);

        // Reset mid-debounce: a full new press is needed afterwards
        keypad = 10'b1 << 2;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        chk("mrst_loadn", 32'(loadn), 32'h1);
        chk("mrst_bcd",   32'(BCD),   32'h0);
        chk("mrst_count", 32'(count), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc(1);
            chk($sformatf("k2_loadn@%0d", k), 32'(loadn), (k == 6) ? 32'h0 : 32'h1);
        end
        chk("k2_bcd",   32'(BCD),   32'h2);
        chk("k2_count", 32'(count), 32'd1);
        keypad = '0;
        cyc(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
